// File: rtl/atari_pot_pkg.sv
// Shared types and default constants for the POKEY pot-scan emulation.
package atari_pot_pkg;

  localparam int unsigned POT_CENTER_DEF = 114;
  localparam int unsigned POT_MAX_DEF    = 228;

  typedef logic [7:0]        pot_t;
  typedef logic signed [7:0] axis_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/pot_axis_map.sv
// Combinational axis-to-pot-target map: centre + 7/8 of the axis, clamped to [1, POT_MAX].
// Optional deadzone around zero when POT_DEADZONE_EN is defined.
module pot_axis_map
  import atari_pot_pkg::*;
#(
  parameter int unsigned POT_CENTER = POT_CENTER_DEF,
  parameter int unsigned POT_MAX    = POT_MAX_DEF,
  parameter int unsigned DEADZONE   = 4
) (
  input  logic [7:0] axis_i,
  input  logic       en_i,
  output logic [7:0] tgt_o
);

  localparam logic signed [10:0] CENTER_S = 11'(POT_CENTER);
  localparam logic signed [10:0] MAX_S    = 11'(POT_MAX);

`ifdef POT_DEADZONE_EN
  localparam logic signed [10:0] DZ_S = 11'(DEADZONE);
`else
  logic dz_unused;
  assign dz_unused = ^DEADZONE;
`endif

  logic signed [10:0] ax_s;
  logic signed [10:0] lin_s;

  always_comb begin
    ax_s  = {{3{axis_i[7]}}, axis_i};
    lin_s = CENTER_S + ((ax_s * 11'sd7) >>> 3);
`ifdef POT_DEADZONE_EN
    if (ax_s < DZ_S && ax_s > -DZ_S) lin_s = CENTER_S;
`endif
    if (!en_i)                tgt_o = MAX_S[7:0];
    else if (lin_s < 11'sd1)  tgt_o = 8'd1;
    else if (lin_s > MAX_S)   tgt_o = MAX_S[7:0];
    else                      tgt_o = lin_s[7:0];
  end

endmodule

// File: rtl/pokey_pot_scan.sv
// POKEY POT0..POTn paddle-scan counters with ALLPOT status; targets latched at POTGO.
// Optional POT_DEADZONE_EN macro enables the axis deadzone inside pot_axis_map.
module pokey_pot_scan
  import atari_pot_pkg::*;
#(
  parameter int unsigned NUM_POT    = 4,
  parameter int unsigned POT_CENTER = POT_CENTER_DEF,
  parameter int unsigned POT_MAX    = POT_MAX_DEF,
  parameter int unsigned DEADZONE   = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ENABLE_15K,
  input  logic                   ENABLE_179,
  input  logic                   FAST_SCAN,
  input  logic                   POT_RESET,
  input  logic                   POTGO,
  input  logic [NUM_POT*8-1:0]   AXIS,
  input  logic [NUM_POT-1:0]     AXIS_EN,
  output logic [NUM_POT*8-1:0]   POT_VALUE,
  output logic [NUM_POT-1:0]     ALLPOT,
  output logic                   SCAN_BUSY
);

  localparam pot_t MAX8 = 8'(POT_MAX);

  pot_t        map_tgt [NUM_POT];
  pot_t        map_q   [NUM_POT];
  pot_t        tgt_q   [NUM_POT];
  pot_t        tgt_d   [NUM_POT];
  pot_t        val_q   [NUM_POT];
  pot_t        val_d   [NUM_POT];
  logic [NUM_POT-1:0] allpot_q, allpot_d;
  pot_t        cnt_q, cnt_d, cnt_inc;
  scan_state_t state_q, state_d;
  logic        tick;

  for (genvar g = 0; g < NUM_POT; g++) begin : g_map
    pot_axis_map #(
      .POT_CENTER (POT_CENTER),
      .POT_MAX    (POT_MAX),
      .DEADZONE   (DEADZONE)
    ) u_map (
      .axis_i (AXIS[8*g +: 8]),
      .en_i   (AXIS_EN[g]),
      .tgt_o  (map_tgt[g])
    );
    assign POT_VALUE[8*g +: 8] = val_q[g];
  end

  assign ALLPOT    = allpot_q;
  assign SCAN_BUSY = |allpot_q;

  // Priority: POT_RESET hold, then POTGO restart, then a count tick.
  always_comb begin
    tick     = FAST_SCAN ? ENABLE_179 : ENABLE_15K;
    cnt_inc  = (cnt_q == MAX8) ? cnt_q : cnt_q + 8'd1;
    cnt_d    = cnt_q;
    allpot_d = allpot_q;
    state_d  = state_q;
    tgt_d    = tgt_q;
    val_d    = val_q;
    if (POT_RESET) begin
      cnt_d    = '0;
      allpot_d = '0;
      state_d  = IDLE;
    end else if (POTGO) begin
      cnt_d    = '0;
      tgt_d    = map_q;
      allpot_d = '1;
      state_d  = SCAN;
    end else if (state_q == SCAN && tick) begin
      cnt_d = cnt_inc;
      for (int unsigned i = 0; i < NUM_POT; i++) begin
        if (allpot_q[i] && (cnt_inc >= tgt_q[i] || cnt_inc == MAX8)) begin
          val_d[i]    = cnt_inc;
          allpot_d[i] = 1'b0;
        end
      end
      if (allpot_d == '0 || cnt_inc == MAX8) state_d = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      allpot_q <= '0;
      for (int unsigned i = 0; i < NUM_POT; i++) begin
        map_q[i] <= MAX8;
        tgt_q[i] <= MAX8;
        val_q[i] <= MAX8;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      allpot_q <= allpot_d;
      map_q    <= map_tgt;
      tgt_q    <= tgt_d;
      val_q    <= val_d;
    end
  end

endmodule

// File: tb/tb_pokey_pot_scan.sv
// Self-checking bench for pokey_pot_scan against a tick-count reference model.
module tb_pokey_pot_scan;
  import atari_pot_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE_15K = 1'b0, ENABLE_179 = 1'b0, FAST_SCAN = 1'b0;
  logic        POT_RESET = 1'b0, POTGO = 1'b0;
  logic [31:0] AXIS = '0;
  logic [3:0]  AXIS_EN = '0;
  logic [31:0] POT_VALUE;
  logic [3:0]  ALLPOT;
  logic        SCAN_BUSY;

  int checks = 0;
  int failures = 0;

  int axis_v [4];
  bit en_v   [4];
  int exp_tgt[4];
  int exp_val[4];
  bit exp_pend[4];
  int exp_k;
  bit exp_active;

  pokey_pot_scan #(.NUM_POT(4), .POT_CENTER(114), .POT_MAX(228), .DEADZONE(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE_15K(ENABLE_15K), .ENABLE_179(ENABLE_179),
    .FAST_SCAN(FAST_SCAN), .POT_RESET(POT_RESET), .POTGO(POTGO), .AXIS(AXIS),
    .AXIS_EN(AXIS_EN), .POT_VALUE(POT_VALUE), .ALLPOT(ALLPOT), .SCAN_BUSY(SCAN_BUSY)
  );

  always #5 CLK = ~CLK;

  // Pot position for a stick axis: centre plus floor(7/8 of the axis), clamped.
  function automatic int ref_map(int a, bit en);
    int p, t;
    if (!en) return 228;
    p = a * 7;
    t = 114 + ((p >= 0) ? p / 8 : -((-p + 7) / 8));
`ifdef POT_DEADZONE_EN
    if (a > -4 && a < 4) t = 114;
`endif
    if (t < 1) t = 1;
    if (t > 228) t = 228;
    return t;
  endfunction

  function automatic logic [31:0] exp_pv();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(exp_val[i]);
    return v;
  endfunction

  function automatic logic [3:0] exp_ap();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = exp_pend[i];
    return v;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_val[i] = 228; exp_pend[i] = 1'b0; exp_tgt[i] = 228;
    end
    exp_k = 0; exp_active = 1'b0;
  endtask

  task automatic apply_axes();
    for (int i = 0; i < 4; i++) begin
      axis_t a;
      a = 8'(axis_v[i]);
      AXIS[8*i +: 8] = a;
      AXIS_EN[i]     = en_v[i];
    end
    step(2);
  endtask

  task automatic rand_axes(bit all_en);
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 5))
        0:       axis_v[i] = -128;
        1:       axis_v[i] = 127;
        2:       axis_v[i] = $urandom_range(0, 8) - 4;
        default: axis_v[i] = $urandom_range(0, 255) - 128;
      endcase
      en_v[i] = all_en ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic do_potgo(bit with_tick);
    POTGO = 1'b1;
    if (with_tick) begin ENABLE_15K = 1'b1; ENABLE_179 = 1'b1; end
    step(1);
    POTGO = 1'b0; ENABLE_15K = 1'b0; ENABLE_179 = 1'b0;
    if (!POT_RESET) begin
      for (int i = 0; i < 4; i++) begin
        exp_tgt[i] = ref_map(axis_v[i], en_v[i]); exp_pend[i] = 1'b1;
      end
      exp_k = 0; exp_active = 1'b1;
    end
  endtask

  // One tick on the selected source, then one cycle pulsing only the other source.
  task automatic do_tick(bit fast);
    FAST_SCAN = fast;
    if (fast) ENABLE_179 = 1'b1; else ENABLE_15K = 1'b1;
    step(1);
    ENABLE_179 = 1'b0; ENABLE_15K = 1'b0;
    if (exp_active && !POT_RESET) begin
      exp_k = (exp_k < 228) ? exp_k + 1 : 228;
      exp_active = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (exp_pend[i] && exp_k >= exp_tgt[i]) begin
          exp_pend[i] = 1'b0; exp_val[i] = exp_tgt[i];
        end
        if (exp_pend[i]) exp_active = 1'b1;
      end
    end
    if (fast) ENABLE_15K = 1'b1; else ENABLE_179 = 1'b1;
    step(1);
    ENABLE_179 = 1'b0; ENABLE_15K = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    model_reset();
    step(2);
    checks++;
    if ({SCAN_BUSY, ALLPOT, POT_VALUE} !== {1'b0, 4'b0000, 32'he4e4e4e4}) begin
      failures++;
      $display("FAIL reset: got busy=%b allpot=%b pv=%h, want busy=0 allpot=0000 pv=e4e4e4e4",
               SCAN_BUSY, ALLPOT, POT_VALUE);
    end
    RESET_N = 1'b1;
    step(1);
  endtask

  task automatic test_directed();
    axis_v = '{-128, 0, 127, 64};
    en_v   = '{1, 1, 1, 1};
    apply_axes();
    do_potgo(1'b0);
    for (int t = 1; t <= 230; t++) begin
      do_tick(1'b0);
      checks++;
      if ({SCAN_BUSY, ALLPOT, POT_VALUE} !== {|exp_ap(), exp_ap(), exp_pv()}) begin
        failures++;
        $display("FAIL directed tick %0d: got busy=%b allpot=%b pv=%h, want busy=%b allpot=%b pv=%h",
                 t, SCAN_BUSY, ALLPOT, POT_VALUE, |exp_ap(), exp_ap(), exp_pv());
      end
    end
    checks++;
    if (POT_VALUE !== {8'd170, 8'd225, 8'd114, 8'd2}) begin
      failures++;
      $display("FAIL directed final: got pv=%h, want pv=aae17202", POT_VALUE);
    end
  endtask

  task automatic test_disabled();
    rand_axes(1'b1);
    en_v = '{1, 1, 0, 0};
    apply_axes();
    do_potgo(1'b0);
    for (int t = 1; t <= 232; t++) begin
      do_tick(1'b0);
      checks++;
      if ({SCAN_BUSY, ALLPOT, POT_VALUE} !== {|exp_ap(), exp_ap(), exp_pv()}) begin
        failures++;
        $display("FAIL disabled tick %0d: got busy=%b allpot=%b pv=%h, want busy=%b allpot=%b pv=%h",
                 t, SCAN_BUSY, ALLPOT, POT_VALUE, |exp_ap(), exp_ap(), exp_pv());
      end
    end
    checks++;
    if (POT_VALUE[31:16] !== 16'he4e4) begin
      failures++;
      $display("FAIL disabled final: got pv[31:16]=%h, want e4e4", POT_VALUE[31:16]);
    end
  endtask

  task automatic test_fast();
    rand_axes(1'b1);
    axis_v[0] = 0;
    apply_axes();
    do_potgo(1'b0);
    for (int t = 1; t <= 114; t++) begin
      do_tick(1'b1);
      checks++;
      if ({SCAN_BUSY, ALLPOT, POT_VALUE} !== {|exp_ap(), exp_ap(), exp_pv()}) begin
        failures++;
        $display("FAIL fast tick %0d: got busy=%b allpot=%b pv=%h, want busy=%b allpot=%b pv=%h",
                 t, SCAN_BUSY, ALLPOT, POT_VALUE, |exp_ap(), exp_ap(), exp_pv());
      end
    end
    checks++;
    if (POT_VALUE[7:0] !== 8'd114 || ALLPOT[0] !== 1'b0) begin
      failures++;
      $display("FAIL fast pot0: got pv0=%0d allpot0=%b, want pv0=114 allpot0=0", POT_VALUE[7:0], ALLPOT[0]);
    end
    for (int t = 0; t < 120; t++) do_tick(1'b1);
    FAST_SCAN = 1'b0;
  endtask

  // Restart mid-scan with a simultaneous tick; axes change before the restart.
  task automatic test_restart();
    rand_axes(1'b1);
    apply_axes();
    do_potgo(1'b0);
    for (int t = 1; t <= 290; t++) begin
      if (t == 50) begin rand_axes(1'b0); apply_axes(); end
      if (t == 56) do_potgo(1'b1);
      do_tick(1'($urandom_range(0, 1)));
      checks++;
      if ({SCAN_BUSY, ALLPOT, POT_VALUE} !== {|exp_ap(), exp_ap(), exp_pv()}) begin
        failures++;
        $display("FAIL restart tick %0d: got busy=%b allpot=%b pv=%h, want busy=%b allpot=%b pv=%h",
                 t, SCAN_BUSY, ALLPOT, POT_VALUE, |exp_ap(), exp_ap(), exp_pv());
      end
    end
    FAST_SCAN = 1'b0;
  endtask

  task automatic test_pot_reset();
    rand_axes(1'b1);
    apply_axes();
    do_potgo(1'b0);
    for (int t = 0; t < 40; t++) do_tick(1'b0);
    POT_RESET = 1'b1;
    step(1);
    exp_active = 1'b0;
    for (int i = 0; i < 4; i++) exp_pend[i] = 1'b0;
    do_potgo(1'b0);
    for (int t = 1; t <= 6; t++) begin
      do_tick(1'b0);
      checks++;
      if ({SCAN_BUSY, ALLPOT, POT_VALUE} !== {1'b0, 4'b0000, exp_pv()}) begin
        failures++;
        $display("FAIL pot_reset %0d: got busy=%b allpot=%b pv=%h, want busy=0 allpot=0000 pv=%h",
                 t, SCAN_BUSY, ALLPOT, POT_VALUE, exp_pv());
      end
    end
    POT_RESET = 1'b0;
    step(1);
  endtask

  task automatic test_async_reset();
    rand_axes(1'b1);
    apply_axes();
    do_potgo(1'b0);
    for (int t = 0; t < 30; t++) do_tick(1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({SCAN_BUSY, ALLPOT, POT_VALUE} !== {1'b0, 4'b0000, 32'he4e4e4e4}) begin
      failures++;
      $display("FAIL async_reset: got busy=%b allpot=%b pv=%h, want busy=0 allpot=0000 pv=e4e4e4e4",
               SCAN_BUSY, ALLPOT, POT_VALUE);
    end
    step(1);
    RESET_N = 1'b1;
    step(1);
  endtask

  task automatic test_random();
    for (int s = 0; s < 4; s++) begin
      rand_axes(1'b0);
      apply_axes();
      do_potgo(1'b0);
      for (int t = 1; t <= 232; t++) begin
        do_tick(1'($urandom_range(0, 1)));
        checks++;
        if ({SCAN_BUSY, ALLPOT, POT_VALUE} !== {|exp_ap(), exp_ap(), exp_pv()}) begin
          failures++;
          $display("FAIL random s%0d tick %0d: got busy=%b allpot=%b pv=%h, want busy=%b allpot=%b pv=%h",
                   s, t, SCAN_BUSY, ALLPOT, POT_VALUE, |exp_ap(), exp_ap(), exp_pv());
        end
      end
    end
    FAST_SCAN = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_disabled();
    test_fast();
    test_restart();
    test_pot_reset();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
